// File: rtl/sink_list_writer.sv
// Producer of a count-prefixed sink-list image: IDs land at BASE_ADDR+1.., the
// count word at BASE_ADDR is written last so a reader never sees a stale N.
module sink_list_writer #(
  parameter int WORD_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_SINKS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  id_valid,
  input  logic [WORD_WIDTH-1:0] id_in,
  input  logic                  id_last,
  input  logic                  finish,
  output logic                  id_ready,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [WORD_WIDTH-1:0] count
);

  localparam logic [WORD_WIDTH-1:0] ADDR_COUNT = WORD_WIDTH'(BASE_ADDR);
  localparam logic [WORD_WIDTH-1:0] ADDR_FIRST = WORD_WIDTH'(BASE_ADDR + 1);
  localparam logic [WORD_WIDTH-1:0] MAX_COUNT  = WORD_WIDTH'(MAX_SINKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE_COUNT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  // One-deep stage between the handshake edge and the write-port registers.
  logic                  pend_q, pend_d;
  logic [WORD_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [WORD_WIDTH-1:0] pend_data_q, pend_data_d;

  logic                  handshake;
  logic [WORD_WIDTH-1:0] count_inc;

  assign id_ready  = (state_q == S_ACCEPT) && (count_q < MAX_COUNT);
  assign handshake = id_valid && id_ready;
  assign count_inc = count_q + WORD_WIDTH'(1);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_d      = 1'b0;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;

    if (pend_q) begin
      wr_en_d = 1'b1;
      addr_d  = pend_addr_q;
      data_d  = pend_data_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ACCEPT;
          count_d    = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_ACCEPT: begin
        if (handshake) begin
          pend_d      = 1'b1;
          pend_addr_d = ADDR_FIRST + count_q;
          pend_data_d = id_in;
          count_d     = count_inc;
        end
        // finish alongside a handshake makes that ID the last one.
        if ((handshake && id_last) || finish) begin
          state_d = S_WRITE_COUNT;
        end else if (handshake && (count_inc == MAX_COUNT)) begin
          state_d    = S_WRITE_COUNT;
          overflow_d = 1'b1;
        end
      end

      S_WRITE_COUNT: begin
        // A trailing ID write still owns the port; the count word follows it.
        if (!pend_q) begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_COUNT;
          data_d  = count_q;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign address     = addr_q;
  assign wr_en       = wr_en_q;
  assign mem_data_in = data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign count       = count_q;

endmodule

// File: tb/tb_sink_list_writer.sv
// Bench for sink_list_writer: a latency-rule model schedules the expected writes
// per edge, a per-cycle compare checks them, and directed lists pin literals.
module tb_sink_list_writer;

  localparam int W    = 16;
  localparam int BASE = 0;
  localparam int MAX  = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         id_valid = 1'b0;
  logic [W-1:0] id_in = '0;
  logic         id_last = 1'b0;
  logic         finish = 1'b0;
  logic         id_ready;
  logic [W-1:0] address;
  logic         wr_en;
  logic [W-1:0] mem_data_in;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [W-1:0] count;

  sink_list_writer #(.WORD_WIDTH(W), .BASE_ADDR(BASE), .MAX_SINKS(MAX)) dut (
    .clock(clock), .reset(reset), .start(start), .id_valid(id_valid),
    .id_in(id_in), .id_last(id_last), .finish(finish), .id_ready(id_ready),
    .address(address), .wr_en(wr_en), .mem_data_in(mem_data_in), .busy(busy),
    .done(done), .overflow(overflow), .count(count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_edge = 0;
  bit tb_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, cyc);
    end
  endtask

  // Memory image as seen through the write port, plus a write counter.
  logic [W-1:0] tb_mem [0:31];
  int wr_count = 0;
  always @(posedge clock) begin
    if (wr_en) begin
      tb_mem[address[4:0]] <= mem_data_in;
      wr_count <= wr_count + 1;
    end
  end

  // Model: an ID accepted at edge k is written after k+1; the count word goes
  // one edge after the last ID write (or after the finish edge), done one later.
  bit           m_active = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_ovf = 1'b0;
  int           m_count = 0;
  int           exp_done = -1;
  int           wrap_end = -1;
  int           rst_edge = -1;
  logic [W-1:0] exp_waddr [int];
  logic [W-1:0] exp_wdata [int];

  always @(posedge clock) begin
    bit hs;
    int cw;
    cyc++;
    if (reset) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
      m_ovf    = 1'b0;
      m_count  = 0;
      exp_done = -1;
      wrap_end = -1;
      rst_edge = cyc;
      exp_waddr.delete();
      exp_wdata.delete();
    end else if (!m_active) begin
      if (cyc == exp_done) m_busy = 1'b0;
      if (start && cyc > wrap_end) begin
        m_active = 1'b1;
        m_busy   = 1'b1;
        m_ovf    = 1'b0;
        m_count  = 0;
      end
    end else begin
      hs = id_valid && (m_count < MAX);
      if (hs) begin
        exp_waddr[cyc+1] = W'(BASE + 1 + m_count);
        exp_wdata[cyc+1] = id_in;
        m_count++;
      end
      if ((hs && id_last) || finish || (hs && m_count == MAX)) begin
        if (hs && !id_last && !finish) m_ovf = 1'b1;
        m_active = 1'b0;
        cw = hs ? cyc + 2 : cyc + 1;
        exp_waddr[cw] = W'(BASE);
        exp_wdata[cw] = W'(m_count);
        exp_done = cw + 1;
        wrap_end = cw + 1;
      end
    end
  end

  always @(negedge clock) begin
    bit we;
    if (cyc > 0 && !tb_done) begin
      we = (exp_waddr.exists(cyc) != 0);
      check("wr_en", wr_en, we);
      if (we) begin
        check("address", address, exp_waddr[cyc]);
        check("mem_data_in", mem_data_in, exp_wdata[cyc]);
      end
      check("done", done, cyc == exp_done);
      check("busy", busy, m_busy);
      check("overflow", overflow, m_ovf);
      check("count", count, m_count);
      check("id_ready", id_ready, m_active && (m_count < MAX));
      if (rst_edge == cyc) begin
        check("rst_address", address, 0);
        check("rst_data", mem_data_in, 0);
      end
    end
  end

  // Drives one cycle of inputs at the falling edge; rdy is id_ready for that cycle.
  task automatic step(input logic r, s, v, input logic [W-1:0] id, input logic l, f,
                      output logic rdy);
    @(negedge clock);
    rdy       = id_ready;
    reset     = r;
    start     = s;
    id_valid  = v;
    id_in     = id;
    id_last   = l;
    finish    = f;
    last_edge = cyc + 1;
  endtask

  task automatic wait_done(output int e);
    logic rdy;
    e = -1;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, '0, 0, 0, rdy);
      if (done) begin
        e = cyc;
        break;
      end
    end
    if (e < 0) check("done_timeout", 1, 0);
  endtask

  initial begin
    logic rdy;
    int   k, e, w0;

    step(1, 0, 0, '0, 0, 0, rdy);
    step(1, 0, 0, '0, 0, 0, rdy);
    check("reset_count", count, 0);
    check("reset_id_ready", id_ready, 0);
    check("reset_busy", busy, 0);
    step(0, 0, 0, '0, 0, 0, rdy);

    // Three IDs back to back, last on the third.
    w0 = wr_count;
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 0, 1, 16'd17, 0, 0, rdy);
    step(0, 0, 1, 16'd3, 0, 0, rdy);
    step(0, 0, 1, 16'd1, 1, 0, rdy);
    k = last_edge;
    wait_done(e);
    check("t1_done_latency", e - k, 3);
    check("t1_mem0", tb_mem[0], 3);
    check("t1_mem1", tb_mem[1], 17);
    check("t1_mem2", tb_mem[2], 3);
    check("t1_mem3", tb_mem[3], 1);
    check("t1_writes", wr_count - w0, 4);

    // Empty list via finish.
    w0 = wr_count;
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 0, 0, '0, 0, 1, rdy);
    k = last_edge;
    wait_done(e);
    check("t2_done_latency", e - k, 2);
    check("t2_mem0", tb_mem[0], 0);
    check("t2_writes", wr_count - w0, 1);

    // Six IDs offered, truncated at MAX=4.
    step(0, 1, 0, '0, 0, 0, rdy);
    for (int i = 0; i < 6; i++) step(0, 0, 1, W'(10 + i), 0, 0, rdy);
    wait_done(e);
    for (int i = 0; i < 4; i++) check("t3_mem_id", tb_mem[i+1], 10 + i);
    check("t3_mem0", tb_mem[0], 4);
    check("t3_overflow", overflow, 1);
    check("t3_count", count, 4);

    // Gapped valid, then finish.
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 0, 1, 16'd5, 0, 0, rdy);
    step(0, 0, 0, 16'd6, 0, 0, rdy);
    step(0, 0, 1, 16'd9, 0, 0, rdy);
    step(0, 0, 0, 16'd7, 0, 0, rdy);
    step(0, 0, 0, '0, 0, 1, rdy);
    wait_done(e);
    check("t4_mem1", tb_mem[1], 5);
    check("t4_mem2", tb_mem[2], 9);
    check("t4_mem0", tb_mem[0], 2);
    check("t4_overflow", overflow, 0);

    // Reset after two of three IDs accepted.
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 0, 1, 16'd21, 0, 0, rdy);
    step(0, 0, 1, 16'd22, 0, 0, rdy);
    step(1, 0, 1, 16'd23, 1, 0, rdy);
    step(0, 0, 0, '0, 0, 0, rdy);
    check("t5_mem0_kept", tb_mem[0], 2);
    check("t5_mem1", tb_mem[1], 21);
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 0, 1, 16'd7, 1, 0, rdy);
    wait_done(e);
    check("t5_rerun_mem1", tb_mem[1], 7);
    check("t5_rerun_mem0", tb_mem[0], 1);

    // id_valid in IDLE, start while busy, finish with a last-ID handshake.
    w0 = wr_count;
    for (int i = 0; i < 3; i++) step(0, 0, 1, W'(40 + i), 1, 0, rdy);
    step(0, 0, 0, '0, 0, 0, rdy);
    check("t6_idle_writes", wr_count - w0, 0);
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 1, 0, '0, 0, 0, rdy);
    step(0, 0, 1, 16'd6, 1, 1, rdy);
    step(0, 1, 0, '0, 0, 0, rdy);
    wait_done(e);
    check("t6_writes", wr_count - w0, 2);
    check("t6_mem1", tb_mem[1], 6);
    check("t6_mem0", tb_mem[0], 1);

    // Randomized lists, with spurious starts and rare resets.
    for (int t = 0; t < 80; t++) begin
      int n, sent;
      bit did_rst;
      logic v, l, f, r;
      n = $urandom_range(0, 6);
      sent = 0;
      did_rst = 1'b0;
      step(0, 1, 1'($urandom_range(0, 1)), W'($urandom), 0, 0, rdy);
      for (int c = 0; c < 40; c++) begin
        v = (sent < n) && ($urandom_range(0, 3) != 0);
        l = v && (sent == n - 1) && ($urandom_range(0, 3) != 0);
        f = (sent >= n) ? ($urandom_range(0, 2) != 0) : (l && $urandom_range(0, 1) == 1);
        r = ($urandom_range(0, 59) == 0);
        step(r, 1'($urandom_range(0, 9) == 0), v, W'($urandom), l, f, rdy);
        if (r) begin
          did_rst = 1'b1;
          break;
        end
        if (!rdy) break;
        if (v) sent++;
      end
      if (did_rst) step(0, 0, 0, '0, 0, 0, rdy);
      else wait_done(e);
      step(0, 0, 1'($urandom_range(0, 1)), W'($urandom), 0, 0, rdy);
    end

    step(0, 0, 0, '0, 0, 0, rdy);
    tb_done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
